// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and the arbiter state type.
package vga_pkg;

  // 640x480@60 Hz horizontal timing (pixels)
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 800

  // 640x480@60 Hz vertical timing (lines)
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Frame buffer: one word per 4x4 screen block
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;

  // The per-line read slot sits four pixels before the end of the line
  localparam int LINE_SLOT_X = H_TOTAL - 4;  // 796

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Linear frame-buffer address from (row, col): row*160 + col as two shifts.
module fb_addr_gen #(
  parameter int AW = 15,
  parameter int RW = 8,
  parameter int CW = 8
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic [AW-1:0] addr
);

  // row*160 = row*128 + row*32; fits in AW bits for every in-range row
  assign addr = (AW'(row) << 7) + (AW'(row) << 5) + AW'(col);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: deadline-fixed VGA prefetch reads, writer
// gets every remaining cycle.
//
// Writer handshake: a write is accepted in any cycle where wr_valid and
// wr_ready are both high; wr_ready does not depend on wr_valid, the writer
// must hold wr_addr/wr_data stable until accepted, and an accepted write is
// committed to the RAM in that same cycle (out-of-range addresses are
// accepted but never written).
module vga_fb_arbiter #(
  parameter int DW   = 12,
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int AW   = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [9:0]      posX,
  input  logic [9:0]      posY,
  output logic [DW-1:0]   pixel_vga,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_we,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata,
  output logic            frame_start,
  output logic            vblank,
  output vga_pkg::state_e state
);

  import vga_pkg::*;

  localparam logic [9:0] X_SLOT = 10'(LINE_SLOT_X);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] X_RD_END = 10'(H_ACTIVE - 4);  // last block has no successor

  state_e          state_nxt;
  logic [9:0]      next_line;
  logic            active_slot;
  logic            line_slot;
  logic            enter_run;
  logic            read_slot;
  logic [7:0]      row_sel;
  logic [7:0]      col_sel;
  logic [AW-1:0]   rd_addr;
  logic            rd_d;
  logic [DW-1:0]   nxt_pix;
  logic [DW-1:0]   cur_pix;

  assign next_line   = (posY == Y_LAST) ? 10'd0 : posY + 10'd1;
  assign active_slot = (posX[1:0] == 2'b00) && (posX < X_RD_END) && (posY < Y_ACT);
  assign line_slot   = (posX == X_SLOT) && (next_line < Y_ACT);
  assign enter_run   = (state == SYNC) && (posX == X_SLOT) && (posY == Y_LAST);
  assign read_slot   = ((state == RUN) || enter_run) && (active_slot || line_slot);

  // Active slot fetches the next block of this row; line slot fetches block 0 of the next line
  assign row_sel = active_slot ? posY[9:2] : next_line[9:2];
  assign col_sel = active_slot ? (posX[9:2] + 8'd1) : 8'd0;

  fb_addr_gen #(.AW(AW), .RW(8), .CW(8)) u_addr_gen (
    .row  (row_sel),
    .col  (col_sel),
    .addr (rd_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  // Next state: lock onto the frame at the row-0 line slot, drop out on illegal counts
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC: if (posX == X_SLOT && posY == Y_LAST) state_nxt = RUN;
      RUN:  if (posX > X_LAST || posY > Y_LAST)  state_nxt = SYNC;
      default: state_nxt = SYNC;
    endcase
  end

  // Prefetch pipeline: capture read data one cycle after the slot, hand over at block end
  always_ff @(posedge clk) begin
    if (rst || state_nxt == SYNC) begin
      rd_d    <= 1'b0;
      nxt_pix <= '0;
      cur_pix <= '0;
    end else begin
      rd_d <= read_slot;
      if (rd_d)               nxt_pix <= ram_rdata;
      if (posX[1:0] == 2'b11) cur_pix <= nxt_pix;
    end
  end

  // Frame-start pulse and vertical blanking flag, both registered
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= (posX == X_LAST) && (posY == Y_LAST) && (state == RUN);
      vblank      <= (posY >= Y_ACT);
    end
  end

  assign pixel_vga = (state == RUN && posX < X_ACT && posY < Y_ACT) ? cur_pix : '0;
  assign wr_ready  = ~rst & ~read_slot;
  assign ram_we    = wr_valid && wr_ready && (wr_addr < AW'(FB_W * FB_H));
  assign ram_addr  = read_slot ? rd_addr : wr_addr;
  assign ram_wdata = wr_data;

endmodule
